// File: rtl/fetch_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_sequencer_pkg
// Brief    : Shared fetch definitions: datapath width, NOP word and the
//            fetch sequencer state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_sequencer_pkg;

  localparam int          CPU_XLEN      = 32;
  localparam logic [31:0] CPU_NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_HOLD = 3'd3,
    ST_DROP = 3'd4
  } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/fetch_sequencer_hold_reg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_sequencer_hold_reg
// Brief    : One-entry instruction + pc buffer used while the hazard unit
//            stalls a response that has already arrived. Clear wins over load.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_sequencer_hold_reg #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,       // asynchronous, active-low
  input  logic            load,
  input  logic            clear,
  input  logic [31:0]     instr_in,
  input  logic [XLEN-1:0] pc_in,
  output logic            valid,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] pc
);

  logic            valid_q, valid_d;
  logic [31:0]     instr_q, instr_d;
  logic [XLEN-1:0] pc_q, pc_d;

  // Next-state for the buffer: clear empties it, load captures a new entry.
  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (clear) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      instr_d = instr_in;
      pc_d    = pc_in;
    end
  end

  // Buffer storage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign valid = valid_q;
  assign instr = instr_q;
  assign pc    = pc_q;

endmodule
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_sequencer
// Brief    : Instruction fetch sequencer. Single-outstanding IMEM request
//            port, pc advance/redirect mux and the IF/ID output registers.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int          XLEN      = CPU_XLEN,
  parameter logic [31:0] NOP_INSTR = CPU_NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst,             // asynchronous, active-low
  input  logic [XLEN-1:0] current_pc,
  output logic [XLEN-1:0] next_pc,
  output logic            pc_write_en,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            fetch_valid,
  output logic [31:0]     fetch_instr,
  output logic [XLEN-1:0] fetch_pc
);

  fetch_state_e    state_q, state_d;
  logic            imem_req_q, imem_req_d;
  logic            fetch_valid_q, fetch_valid_d;
  logic [31:0]     fetch_instr_q, fetch_instr_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;

  logic            hold_load, hold_clear, hold_valid;
  logic [31:0]     hold_instr;
  logic [XLEN-1:0] hold_pc;
  logic [XLEN-1:0] pc_plus4;
  logic            unused_redirect_lsbs;

  // Redirect targets are word aligned, so the low bits are dropped.
  assign unused_redirect_lsbs = ^redirect_pc[1:0];
  assign pc_plus4             = current_pc + {{(XLEN-3){1'b0}}, 3'd4};

  fetch_sequencer_hold_reg #(.XLEN(XLEN)) u_hold (
    .clk      (clk),
    .rst      (rst),
    .load     (hold_load),
    .clear    (hold_clear),
    .instr_in (imem_rdata),
    .pc_in    (current_pc),
    .valid    (hold_valid),
    .instr    (hold_instr),
    .pc       (hold_pc)
  );

  // Next state, pc mux and IF/ID next values; redirect overrides everything.
  always_comb begin
    state_d       = state_q;
    pc_write_en   = 1'b0;
    next_pc       = current_pc;
    fetch_valid_d = fetch_valid_q;
    fetch_instr_d = fetch_instr_q;
    fetch_pc_d    = fetch_pc_q;
    hold_load     = 1'b0;
    hold_clear    = 1'b0;

    if ((state_q != ST_IDLE) && redirect_valid) begin
      pc_write_en   = 1'b1;
      next_pc       = {redirect_pc[XLEN-1:2], 2'b00};
      fetch_valid_d = 1'b0;
      fetch_instr_d = NOP_INSTR;
      hold_clear    = 1'b1;
      case (state_q)
        // A request granted now still returns a word that must be thrown away.
        ST_REQ:  state_d = imem_gnt ? ST_DROP : ST_REQ;
        ST_WAIT: state_d = imem_rvalid ? ST_REQ : ST_DROP;
        ST_DROP: state_d = imem_rvalid ? ST_REQ : ST_DROP;
        default: state_d = ST_REQ;
      endcase
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_REQ;
        ST_REQ: begin
          if (imem_gnt) state_d = ST_WAIT;
        end
        ST_WAIT: begin
          if (imem_rvalid) begin
            if (!stall) begin
              fetch_valid_d = 1'b1;
              fetch_instr_d = imem_rdata;
              fetch_pc_d    = current_pc;
              pc_write_en   = 1'b1;
              next_pc       = pc_plus4;
              state_d       = ST_REQ;
            end else begin
              hold_load = 1'b1;
              state_d   = ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (!stall) begin
            if (hold_valid) begin
              fetch_valid_d = 1'b1;
              fetch_instr_d = hold_instr;
              fetch_pc_d    = hold_pc;
            end
            hold_clear  = 1'b1;
            pc_write_en = 1'b1;
            next_pc     = pc_plus4;
            state_d     = ST_REQ;
          end
        end
        ST_DROP: begin
          if (imem_rvalid) state_d = ST_REQ;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    imem_req_d = (state_d == ST_REQ);
  end

  // State, request and IF/ID registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      imem_req_q    <= 1'b0;
      fetch_valid_q <= 1'b0;
      fetch_instr_q <= NOP_INSTR;
      fetch_pc_q    <= '0;
    end else begin
      state_q       <= state_d;
      imem_req_q    <= imem_req_d;
      fetch_valid_q <= fetch_valid_d;
      fetch_instr_q <= fetch_instr_d;
      fetch_pc_q    <= fetch_pc_d;
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = current_pc;
  assign fetch_valid = fetch_valid_q;
  assign fetch_instr = fetch_instr_q;
  assign fetch_pc    = fetch_pc_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_sequencer
// Brief    : Self-checking bench for fetch_sequencer. Transaction-level model
//            of the fetch pipeline, an IMEM responder and a pc register.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] current_pc, next_pc, imem_addr, imem_rdata, redirect_pc;
  logic [31:0] fetch_instr, fetch_pc;
  logic        pc_write_en, imem_req, imem_gnt, imem_rvalid, stall;
  logic        redirect_valid, fetch_valid;

  always #5 clk = ~clk;

  fetch_sequencer dut (
    .clk(clk), .rst(rst), .current_pc(current_pc), .next_pc(next_pc),
    .pc_write_en(pc_write_en), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fetch_valid(fetch_valid), .fetch_instr(fetch_instr), .fetch_pc(fetch_pc)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---- transaction-level model: what is outstanding, what is owed ----
  bit          m_started, m_req, m_inflight, m_discard, m_held, m_fv;
  logic [31:0] m_hi, m_hp, m_fi, m_fp;
  // ---- IMEM responder ----
  bit          mem_busy;
  int          mem_cnt;
  logic [31:0] mem_addr;
  int          gnt_pct = 100, min_lat = 1, max_lat = 1;
  // ---- logs ----
  logic [31:0] grant_q[$];
  logic [31:0] fetched_pc_q[$];
  logic        obs_pwe;
  logic [31:0] obs_npc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A3C_0000;
  endfunction

  task automatic model_reset();
    m_started = 0; m_req = 0; m_inflight = 0; m_discard = 0; m_held = 0;
    m_fv = 0; m_fi = NOP; m_fp = 32'h0;
  endtask

  // One clock cycle: drive inputs, compare every output, advance the model.
  task automatic step(input bit st, input bit rd, input logic [31:0] rpc);
    bit          redir, pwe_e;
    logic [31:0] npc_e;
    @(negedge clk);
    stall          = st;
    redirect_valid = rd;
    redirect_pc    = rpc;
    imem_rvalid    = mem_busy && (mem_cnt == 0);
    imem_rdata     = imem_rvalid ? mem_word(mem_addr) : $urandom;
    imem_gnt       = m_req && !mem_busy && (int'($urandom_range(99)) < gnt_pct);
    #1;
    redir = rd && m_started;
    if (redir) begin
      pwe_e = 1; npc_e = {rpc[31:2], 2'b00};
    end else if (!st && ((m_inflight && imem_rvalid && !m_discard) || m_held)) begin
      pwe_e = 1; npc_e = current_pc + 32'd4;
    end else begin
      pwe_e = 0; npc_e = current_pc;
    end
    check("imem_req", 32'(imem_req), 32'(m_req));
    if (m_req) check("imem_addr", imem_addr, current_pc);
    check("fetch_valid", 32'(fetch_valid), 32'(m_fv));
    check("fetch_instr", fetch_instr, m_fi);
    check("fetch_pc", fetch_pc, m_fp);
    check("pc_write_en", 32'(pc_write_en), 32'(pwe_e));
    check("next_pc", next_pc, npc_e);
    obs_pwe = pc_write_en;
    obs_npc = next_pc;

    if (m_req && imem_gnt) grant_q.push_back(current_pc);
    if (!m_started) begin
      m_started = 1; m_req = 1;
    end else if (redir) begin
      m_fv = 0; m_fi = NOP; m_held = 0;
      if (m_req) begin
        if (imem_gnt) begin m_req = 0; m_inflight = 1; m_discard = 1; end
      end else if (m_inflight) begin
        if (imem_rvalid) begin m_inflight = 0; m_req = 1; end
        else m_discard = 1;
      end else begin
        m_req = 1;
      end
    end else if (m_req) begin
      if (imem_gnt) begin m_req = 0; m_inflight = 1; m_discard = 0; end
    end else if (m_inflight) begin
      if (imem_rvalid) begin
        m_inflight = 0;
        if (m_discard) m_req = 1;
        else if (!st) begin
          m_fv = 1; m_fi = imem_rdata; m_fp = current_pc; m_req = 1;
          fetched_pc_q.push_back(current_pc);
        end else begin
          m_held = 1; m_hi = imem_rdata; m_hp = current_pc;
        end
      end
    end else if (m_held && !st) begin
      m_fv = 1; m_fi = m_hi; m_fp = m_hp; m_held = 0; m_req = 1;
      fetched_pc_q.push_back(m_hp);
    end

    if (imem_rvalid) mem_busy = 0;
    else if (mem_busy) mem_cnt--;
    if (imem_gnt) begin
      mem_busy = 1; mem_addr = current_pc;
      mem_cnt  = int'($urandom_range(max_lat - 1, min_lat - 1));
    end

    @(posedge clk);
    #1;
    if (pwe_e) current_pc = npc_e;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " imem_req"}, 32'(imem_req), 32'd0);
    check({tag, " fetch_valid"}, 32'(fetch_valid), 32'd0);
    check({tag, " fetch_instr"}, fetch_instr, NOP);
    check({tag, " fetch_pc"}, fetch_pc, 32'h0);
    check({tag, " pc_write_en"}, 32'(pc_write_en), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [31:0] a0;
    rst = 1'b0; current_pc = 0; stall = 0; redirect_valid = 0; redirect_pc = 0;
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0;
    mem_busy = 0; mem_cnt = 0; mem_addr = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b1;

    // 1: 1-cycle memory, no stall: first word visible after three cycles
    repeat (3) step(0, 0, 0);
    check("first fetch_valid", 32'(fetch_valid), 32'd1);
    check("first fetch_pc", fetch_pc, 32'h0);
    check("first fetch_instr", fetch_instr, mem_word(32'h0));
    check("first pc advance", current_pc, 32'h4);
    repeat (5) step(0, 0, 0);
    check("grant addr 0", grant_q[0], 32'h0);
    check("grant addr 1", grant_q[1], 32'h4);
    check("grant addr 2", grant_q[2], 32'h8);
    check("fetched pc 1", fetched_pc_q[1], 32'h4);
    check("fetched pc 2", fetched_pc_q[2], 32'h8);

    // 2: stall on the response at pc 0x10
    for (int i = 0; i < 20 && !(m_inflight && current_pc == 32'h10); i++) step(0, 0, 0);
    check("reach pc 0x10", 32'(m_inflight && current_pc == 32'h10), 32'd1);
    step(1, 0, 0);
    check("stall no pc write", 32'(obs_pwe), 32'd0);
    check("stall fetch_pc frozen", fetch_pc, 32'hC);
    step(1, 0, 0);
    check("stall pc held", current_pc, 32'h10);
    step(0, 0, 0);
    check("unstall next_pc", obs_npc, 32'h14);
    check("unstall fetch_pc", fetch_pc, 32'h10);
    check("unstall fetch_instr", fetch_instr, mem_word(32'h10));

    // 3: redirect in WAIT before the response arrives
    min_lat = 3; max_lat = 3;
    for (int i = 0; i < 20 && !(m_inflight && mem_cnt > 0); i++) step(0, 0, 0);
    step(0, 1, 32'h200);
    check("redir next_pc", obs_npc, 32'h200);
    check("redir fetch_valid", 32'(fetch_valid), 32'd0);
    n = grant_q.size();
    for (int i = 0; i < 20 && grant_q.size() == n; i++) step(0, 0, 0);
    check("redir grant addr", (grant_q.size() > n) ? grant_q[n] : 32'hFFFF_FFFF, 32'h200);

    // 4: redirect with stall while a word is held
    min_lat = 1; max_lat = 1;
    for (int i = 0; i < 20 && !(m_inflight && mem_cnt == 0 && !m_discard); i++) step(0, 0, 0);
    step(1, 0, 0);
    check("held entry", 32'(m_held), 32'd1);
    step(1, 1, 32'h300);
    check("hold redir fetch_valid", 32'(fetch_valid), 32'd0);
    check("hold redir pc", current_pc, 32'h300);
    n = fetched_pc_q.size();
    for (int i = 0; i < 20 && fetched_pc_q.size() == n; i++) step(0, 0, 0);
    step(0, 0, 0);
    check("after hold redir fetch_pc", fetch_pc, 32'h300);

    // 5: unaligned redirect target and pc wrap
    step(0, 1, 32'h203);
    check("align next_pc", obs_npc, 32'h200);
    step(0, 1, 32'hFFFF_FFFE);
    n = fetched_pc_q.size();
    for (int i = 0; i < 20 && fetched_pc_q.size() == n; i++) step(0, 0, 0);
    check("wrap fetched pc", fetch_pc, 32'hFFFF_FFFC);
    check("wrap pc", current_pc, 32'h0);

    // 6: grant withheld for five cycles
    gnt_pct = 0;
    for (int i = 0; i < 20 && !m_req; i++) step(0, 0, 0);
    a0 = current_pc;
    repeat (5) step(0, 0, 0);
    check("no gnt imem_req", 32'(imem_req), 32'd1);
    check("no gnt imem_addr", imem_addr, a0);
    gnt_pct = 100;

    // randomized traffic
    gnt_pct = 60; min_lat = 1; max_lat = 3;
    for (int i = 0; i < 3000; i++)
      step(int'($urandom_range(99)) < 25, int'($urandom_range(99)) < 5, $urandom);

    // asynchronous reset while a response is outstanding
    gnt_pct = 100; min_lat = 3; max_lat = 3;
    for (int i = 0; i < 20 && !(m_inflight && mem_cnt > 0); i++) step(0, 0, 0);
    check("reach WAIT", 32'(m_inflight && mem_cnt > 0), 32'd1);
    #2 rst = 1'b0;
    #1;
    check_reset_outputs("midreset");
    model_reset();
    current_pc = 0;
    @(posedge clk);
    #1 rst = 1'b1;
    min_lat = 1; max_lat = 1;
    n = fetched_pc_q.size();
    repeat (12) step(0, 0, 0);
    check("post reset first fetch", (fetched_pc_q.size() > n) ? fetched_pc_q[n] : 32'hFFFF_FFFF, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
